// File: rtl/trap_peak_detector_if.sv
// AXI4-Stream style sample/peak channel shared by the trapezoid peak detector.
// The producer drives tdata/tvalid (and tuser when timestamps are built in);
// the consumer drives tready.
// Build option: define PEAK_TIMESTAMP_EN to add the tuser timestamp field.
interface trap_peak_detector_if #(
    parameter int DATA_WIDTH = 32
`ifdef PEAK_TIMESTAMP_EN
    , parameter int TS_WIDTH = 32
`endif
);
    logic signed [DATA_WIDTH-1:0] tdata;
    logic                         tvalid;
    logic                         tready;
`ifdef PEAK_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]          tuser;

    modport master (output tdata, output tvalid, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tuser, output tready);
`else
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/trap_peak_detector.sv
// Peak detector for a trapezoidal-filter output stream.
// Arms when a valid sample rises above the threshold, then captures either
// the sample in the middle of the flat top (mode 0) or the running maximum
// of the pulse (mode 1). Each accepted pulse produces one output beat.
// After a pulse the detector waits for the signal to fall below the re-arm
// level (threshold - hysteresis), then ignores `holdoff` valid samples.
// Pulses that fall back before the mid-flat-top capture point are rejected
// and counted; captures that find the output still occupied are dropped and
// counted. Both counters saturate.
// Build option: PEAK_TIMESTAMP_EN adds m_axis.tuser carrying the
// valid-sample index of the crossing sample.
module trap_peak_detector #(
    parameter int DATA_WIDTH  = 32,
    parameter int DELAY_WIDTH = 14,
    parameter int CNT_WIDTH   = 16
`ifdef PEAK_TIMESTAMP_EN
    , parameter int TS_WIDTH  = 32
`endif
) (
    input  logic                   clk,
    input  logic                   aresetn,
    trap_peak_detector_if.slave    s_axis,
    trap_peak_detector_if.master   m_axis,
    input  logic [15:0]            threshold_i,
    input  logic [15:0]            hysteresis_i,
    input  logic [DELAY_WIDTH-1:0] kdelay_i,
    input  logic [DELAY_WIDTH-1:0] ldelay_i,
    input  logic [DELAY_WIDTH-1:0] holdoff_i,
    input  logic                   mode_i,
    output logic [CNT_WIDTH-1:0]   reject_count_o,
    output logic [CNT_WIDTH-1:0]   drop_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REARM,
        ST_HOLDOFF
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                        state_q;
    logic [DELAY_WIDTH:0]          cnt_q;
    logic [DELAY_WIDTH-1:0]        hold_q;
    logic signed [DATA_WIDTH-1:0]  max_q;
    logic                          mode_q;

    logic signed [DATA_WIDTH-1:0]  tdata_q;
    logic                          tvalid_q;
    logic [CNT_WIDTH-1:0]          reject_q;
    logic [CNT_WIDTH-1:0]          drop_q;

    // ------------------------------------------------------------------
    // Sample compare path
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0]  sample;
    logic                          sample_valid;
    logic signed [DATA_WIDTH-1:0]  thr_ext;
    logic signed [DATA_WIDTH:0]    thr_wide;
    logic signed [DATA_WIDTH:0]    hyst_wide;
    logic signed [DATA_WIDTH:0]    rearm_lvl;
    logic signed [DATA_WIDTH:0]    sample_wide;
    logic                          above_thr;
    logic                          below_rearm;
    logic [DELAY_WIDTH:0]          capt_sum;
    logic [DELAY_WIDTH:0]          capt;
    logic                          capt_zero;
    state_t                        after_pulse_state;

    assign sample       = s_axis.tdata;
    assign sample_valid = s_axis.tvalid;

    // The detector consumes every sample it is offered.
    assign s_axis.tready = 1'b1;

    assign thr_ext     = DATA_WIDTH'($signed(threshold_i));
    assign thr_wide    = (DATA_WIDTH+1)'(thr_ext);
    assign hyst_wide   = $signed({{(DATA_WIDTH-15){1'b0}}, hysteresis_i});
    // One extra bit so a large hysteresis below a negative threshold cannot wrap.
    assign rearm_lvl   = thr_wide - hyst_wide;
    assign sample_wide = (DATA_WIDTH+1)'(sample);

    assign above_thr   = sample_valid && (sample > thr_ext);
    assign below_rearm = sample_valid && (sample_wide < rearm_lvl);

    // Middle of the flat top, counted in samples from the crossing sample.
    assign capt_sum  = {1'b0, kdelay_i} + {1'b0, ldelay_i};
    assign capt      = capt_sum >> 1;
    assign capt_zero = (capt == '0);

    // A zero hold-off skips the hold-off state entirely.
    assign after_pulse_state = (holdoff_i == '0) ? ST_IDLE : ST_HOLDOFF;

    // ------------------------------------------------------------------
    // Capture / reject decode for the current cycle
    // ------------------------------------------------------------------
    logic                          cap_fire;
    logic                          cap_at_cross;
    logic signed [DATA_WIDTH-1:0]  cap_data;
    logic                          reject_fire;

    // Decide whether this cycle produces a peak value or a rejected pulse.
    always_comb begin
        cap_fire     = 1'b0;
        cap_at_cross = 1'b0;
        cap_data     = sample;
        reject_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (above_thr && !mode_i && capt_zero) begin
                    cap_fire     = 1'b1;
                    cap_at_cross = 1'b1;
                end
            end
            ST_WAIT: begin
                if (sample_valid) begin
                    if (!mode_q) begin
                        // The capture sample itself wins over a late fall.
                        if (cnt_q == (DELAY_WIDTH+1)'(1)) begin
                            cap_fire = 1'b1;
                        end else if (below_rearm) begin
                            reject_fire = 1'b1;
                        end
                    end else if (below_rearm) begin
                        cap_fire = 1'b1;
                        cap_data = max_q;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Pulse tracking state machine; only valid samples advance it.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            max_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (above_thr) begin
                        // Pulse parameters are frozen at the crossing sample.
                        mode_q <= mode_i;
                        max_q  <= sample;
                        cnt_q  <= capt;
                        if (!mode_i && capt_zero) begin
                            state_q <= ST_REARM;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sample_valid) begin
                        if (!mode_q) begin
                            if (cnt_q == (DELAY_WIDTH+1)'(1)) begin
                                state_q <= ST_REARM;
                            end else if (below_rearm) begin
                                hold_q  <= holdoff_i;
                                state_q <= after_pulse_state;
                            end else begin
                                cnt_q <= cnt_q - (DELAY_WIDTH+1)'(1);
                            end
                        end else if (below_rearm) begin
                            hold_q  <= holdoff_i;
                            state_q <= after_pulse_state;
                        end else if (sample > max_q) begin
                            // Strict compare keeps the first of equal maxima.
                            max_q <= sample;
                        end
                    end
                end
                ST_REARM: begin
                    if (below_rearm) begin
                        hold_q  <= holdoff_i;
                        state_q <= after_pulse_state;
                    end
                end
                ST_HOLDOFF: begin
                    if (sample_valid) begin
                        if (hold_q <= DELAY_WIDTH'(1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            hold_q <= hold_q - DELAY_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PEAK_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_q;
    logic [TS_WIDTH-1:0] ts_cross_q;
    logic [TS_WIDTH-1:0] tuser_q;
    logic [TS_WIDTH-1:0] cap_ts;

    assign cap_ts = cap_at_cross ? ts_cnt_q : ts_cross_q;

    // Free-running valid-sample index, latched at every crossing sample.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ts_cnt_q   <= '0;
            ts_cross_q <= '0;
        end else begin
            if (sample_valid) begin
                ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
            end
            if (state_q == ST_IDLE && above_thr) begin
                ts_cross_q <= ts_cnt_q;
            end
        end
    end

    // Timestamp travels with the peak value.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            tuser_q <= '0;
        end else if (cap_fire && (!tvalid_q || m_axis.tready)) begin
            tuser_q <= cap_ts;
        end
    end

    assign m_axis.tuser = tuser_q;
`else
    logic unused_cross;
    assign unused_cross = cap_at_cross;
`endif

    // Output register: load on capture if the slot is free or draining,
    // otherwise drop the new peak; clear tvalid after a plain handshake.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (cap_fire) begin
                if (!tvalid_q || m_axis.tready) begin
                    tdata_q  <= cap_data;
                    tvalid_q <= 1'b1;
                end else if (drop_q != '1) begin
                    drop_q <= drop_q + CNT_WIDTH'(1);
                end
            end else if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    // Saturating count of pulses that fell back before their capture point.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            reject_q <= '0;
        end else if (reject_fire && reject_q != '1) begin
            reject_q <= reject_q + CNT_WIDTH'(1);
        end
    end

    assign m_axis.tdata   = tdata_q;
    assign m_axis.tvalid  = tvalid_q;
    assign reject_count_o = reject_q;
    assign drop_count_o   = drop_q;

endmodule

// File: tb/tb_trap_peak_detector.sv
// Directed testbench for trap_peak_detector: hand-built pulses with
// hand-computed peak values, counters and output handshake behaviour.
module tb_trap_peak_detector;

    localparam int DW  = 32;
    localparam int DLW = 14;
    localparam int CW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              aresetn;
    logic [15:0]       threshold;
    logic [15:0]       hysteresis;
    logic [DLW-1:0]    kdelay;
    logic [DLW-1:0]    ldelay;
    logic [DLW-1:0]    holdoff;
    logic              mode;
    logic [CW-1:0]     reject_count;
    logic [CW-1:0]     drop_count;

`ifdef PEAK_TIMESTAMP_EN
    trap_peak_detector_if #(.DATA_WIDTH(DW), .TS_WIDTH(32)) s_if ();
    trap_peak_detector_if #(.DATA_WIDTH(DW), .TS_WIDTH(32)) m_if ();
`else
    trap_peak_detector_if #(.DATA_WIDTH(DW)) s_if ();
    trap_peak_detector_if #(.DATA_WIDTH(DW)) m_if ();
`endif

    trap_peak_detector #(
        .DATA_WIDTH  (DW),
        .DELAY_WIDTH (DLW),
        .CNT_WIDTH   (CW)
`ifdef PEAK_TIMESTAMP_EN
        , .TS_WIDTH  (32)
`endif
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .threshold_i    (threshold),
        .hysteresis_i   (hysteresis),
        .kdelay_i       (kdelay),
        .ldelay_i       (ldelay),
        .holdoff_i      (holdoff),
        .mode_i         (mode),
        .reject_count_o (reject_count),
        .drop_count_o   (drop_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s value=%0d", tag, got);
        end
    endtask

    // Present one valid sample, then settle just after the edge that consumed it.
    task automatic put(input int v);
        @(negedge clk);
        s_if.tdata  = v;
        s_if.tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_if.tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        aresetn     = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
`ifdef PEAK_TIMESTAMP_EN
        s_if.tuser  = '0;
`endif
        m_if.tready = 1'b1;
        threshold   = 16'd100;
        hysteresis  = 16'd50;
        kdelay      = 14'd4;
        ldelay      = 14'd8;
        holdoff     = 14'd0;
        mode        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_tdata", 64'($unsigned(m_if.tdata)), 64'd0);
        chk("rst_reject", 64'(reject_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;

        // Mode 0, K=4 L=8: capture point is index 6.
        put(0);
        put(250); put(500); put(750); put(1000);
        put(1002); put(1004);
        chk("m0_before_capt", 64'(m_if.tvalid), 64'd0);
        put(1006);
        chk("m0_tvalid", 64'(m_if.tvalid), 64'd1);
        chk("m0_tdata", 64'($unsigned(m_if.tdata)), 64'd1006);
        put(1008);
        chk("m0_beat_done", 64'(m_if.tvalid), 64'd0);
        put(750); put(500); put(250); put(0);
        chk("m0_no_retrig", 64'(m_if.tvalid), 64'd0);

        // Mode 1: running maximum, emitted on the fall sample.
        mode = 1'b1;
        put(50); put(200); put(800); put(1234); put(1100); put(900);
        chk("m1_before_fall", 64'(m_if.tvalid), 64'd0);
        put(30);
        chk("m1_tvalid", 64'(m_if.tvalid), 64'd1);
        chk("m1_tdata", 64'($unsigned(m_if.tdata)), 64'd1234);
        put(0);
        chk("m1_single_beat", 64'(m_if.tvalid), 64'd0);

        // Mode 0, K=L=10: falls below re-arm at index 3, rejected.
        mode   = 1'b0;
        kdelay = 14'd10;
        ldelay = 14'd10;
        put(300); put(400); put(500); put(20);
        put(10); put(10);
        chk("rej_no_beat", 64'(m_if.tvalid), 64'd0);
        chk("rej_count", 64'(reject_count), 64'd1);

        // Output held with tready low: second peak dropped.
        mode        = 1'b1;
        m_if.tready = 1'b0;
        put(200); put(700); put(10);
        chk("bp_first_valid", 64'(m_if.tvalid), 64'd1);
        put(300); put(10);
        chk("bp_drop", 64'(drop_count), 64'd1);
        chk("bp_data_kept", 64'($unsigned(m_if.tdata)), 64'd700);
        chk("bp_still_valid", 64'(m_if.tvalid), 64'd1);
        m_if.tready = 1'b1;
        idle(1);
        chk("bp_released", 64'(m_if.tvalid), 64'd0);
        chk("bp_drop_stable", 64'(drop_count), 64'd1);

        // Hysteresis ripple and hold-off of 5 valid samples.
        mode    = 1'b0;
        kdelay  = 14'd2;
        ldelay  = 14'd2;
        holdoff = 14'd5;
        put(500); put(500); put(500);
        chk("ho_first_tdata", 64'($unsigned(m_if.tdata)), 64'd500);
        put(120); put(60); put(120); put(60);
        chk("ho_ripple_quiet", 64'(m_if.tvalid), 64'd0);
        put(40);
        put(500); put(500); put(500); put(500); put(500);
        put(500); put(500);
        chk("ho_skip_honoured", 64'(m_if.tvalid), 64'd0);
        put(777);
        chk("ho_retrig_valid", 64'(m_if.tvalid), 64'd1);
        chk("ho_retrig_tdata", 64'($unsigned(m_if.tdata)), 64'd777);
        put(10);
        holdoff = 14'd0;
        put(10); put(10); put(10); put(10); put(10);

        // Reset in the middle of a pulse with an output beat pending.
        mode        = 1'b1;
        m_if.tready = 1'b0;
        put(400); put(10);
        chk("rs_pending", 64'(m_if.tvalid), 64'd1);
        put(500); put(600);
        @(negedge clk);
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("rs_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rs_tdata", 64'($unsigned(m_if.tdata)), 64'd0);
        chk("rs_reject", 64'(reject_count), 64'd0);
        @(negedge clk);
        aresetn     = 1'b1;
        m_if.tready = 1'b1;

        // Fresh pulse after reset: crossing is valid-sample index 37.
        for (int i = 0; i < 37; i++) put(10);
        chk("rs_idle_quiet", 64'(m_if.tvalid), 64'd0);
        put(300); put(10);
        chk("rs_new_tvalid", 64'(m_if.tvalid), 64'd1);
        chk("rs_new_tdata", 64'($unsigned(m_if.tdata)), 64'd300);
`ifdef PEAK_TIMESTAMP_EN
        chk("ts_tuser", 64'(m_if.tuser), 64'd37);
`endif
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
